mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
// - MEM-stage consumer of the EX/MEM pipeline register outputs: result, MemData, MemOp, WriteRegDst, RegWrite.
// - Runs loads and stores over a req/ack data-memory bus.
// - Stalls the pipeline via stall_req_o until the access completes.
// - Presents write-back data, destination and enable to the MEM/WB register.
// PARAMETERS
// - ACK_TIMEOUT   255   Cycles in BUSY without mem_ack before the access is aborted as a bus error (1..255).
// PORTS
// - clk            in   1   Clock.
// - rst            in   1   Reset; synchronous, active-low.
// - result_i       in   32  ALU result: memory byte address for load/store, write-back value otherwise.
// - MemData_i      in   32  Store data (rt value).
// - MemOp_i        in   3   Memory operation; encoding below.
// - WriteRegDst_i  in   5   Destination register.
// - RegWrite_i     in   1   Register write enable.
// - mem_req        out  1   Bus request; held until ack or timeout.
// - mem_we         out  1   1 = store.
// - mem_addr       out  32  Word address {result_i[31:2],2'b00}.
// - mem_be         out  4   Byte enables, little-endian lanes.
// - mem_wdata      out  32  Store data, lane-replicated.
// - mem_rdata      in   32  Read data; valid while mem_ack=1.
// - mem_ack        in   1   Access complete.
// - stall_req_o    out  1   Hold IF..EX/MEM (hazard unit issues keep on ExMemOp).
// - wb_data_o      out  32  Write-back value.
// - WriteRegDst_o  out  5   Destination register.
// - RegWrite_o     out  1   Write enable; 0 during stall and on bus error.
// - bus_err_o      out  1   One-cycle pulse on timeout.
// BEHAVIOUR
// - MemOp encoding: 000 NOP, 001 LW, 010 LB, 011 LBU, 100 LHU, 101 SW, 110 SB, 111 SH.
// - FSM states:
//   - IDLE: MemOp_i!=NOP -> drive req/we/addr/be/wdata registered, go BUSY.
//   - BUSY: mem_ack=1 -> capture lane-extracted rdata into ld_q, go DONE. Count reaches ACK_TIMEOUT -> ld_q=0, pulse bus_err_o, go DONE.
//   - DONE: pipeline advances this cycle; go IDLE.
// - stall_req_o = (state==IDLE && MemOp_i!=NOP) || state==BUSY. Combinational. Low in DONE.
// - Latency: load/store completes min 3 cycles (IDLE, BUSY with ack, DONE). NOP takes 0 stall cycles.
// - wb_data_o:
//   - Load in DONE: ld_q.
//   - Otherwise: result_i.
//   - WriteRegDst_o = WriteRegDst_i.
// - RegWrite_o:
//   - RegWrite_i when state==DONE or op is NOP; 0 otherwise.
//   - Forced 0 in DONE after timeout.
// - Lanes, a = result_i[1:0]:
//   - SB: be = 1<<a; wdata = {4{MemData_i[7:0]}}.
//   - SH: be = a[1] ? 1100 : 0011; wdata = {2{MemData_i[15:0]}}.
//   - SW: be = 1111.
//   - Loads: be = 1111. LB sign-extends byte a; LBU zero-extends it; LHU zero-extends half a[1].
// - mem_ack while not BUSY: ignored.
// - Ack and timeout in the same cycle: ack wins.
// - Reset values (rst=0): state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0, ld_q 0, timeout counter 0, bus_err_o 0.
// - Reset mid-BUSY aborts the access; no ack is awaited.
// - Timeout counter clears on entry to BUSY.
// - Outputs other than the bus are combinational from the state and inputs.
// CONFIGURATION
// - MEM_ALIGN_CHECK_EN defined:
//   - LW/SW with a!=0, or LHU/SH with a[0]=1, skips the bus entirely.
//   - IDLE -> DONE directly: 1 stall cycle, RegWrite_o=0, bus_err_o pulses.
// - MEM_ALIGN_CHECK_EN undefined:
//   - Word access ignores a.
//   - Halfword access ignores a[0].
// STRUCTURE
// - defines.v holds: MEMOP_* codes, FSM state codes, default ACK_TIMEOUT. Also `ZeroWord and the DEFAULT_* reset values.
// - Sub-module mem_lane_align: combinational be/wdata generation and load extraction/extension. FSM and counter stay in the top.
// TESTING
// - LW, result_i=0x100, ack 2 cycles after req:
//   - mem_addr=0x100, be=1111.
//   - stall_req_o high 3 cycles.
//   - DONE: wb_data_o=rdata, RegWrite_o=1.
// - LB, a=3, rdata=0x80FFFFFF -> wb_data_o=0xFFFFFF80. LBU, same input -> 0x00000080.
// - SB, a=2, MemData_i=0x12345678 -> be=0100, wdata=0x78787878, mem_we=1, RegWrite_o=0.
// - No ack, ACK_TIMEOUT=4 -> mem_req drops after 4 BUSY cycles, bus_err_o pulse, RegWrite_o=0.
// - rst low mid-BUSY -> next cycle mem_req=0, state IDLE. A late ack is then ignored.
// - MEM_ALIGN_CHECK_EN, SW at 0x102 -> mem_req never asserted, one stall cycle, bus_err_o=1.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: memory-op codes, FSM
// state encoding, the default ack timeout and reset constants.
package mem_access_unit_pkg;

  localparam logic [2:0] MEMOP_NOP = 3'b000;
  localparam logic [2:0] MEMOP_LW  = 3'b001;
  localparam logic [2:0] MEMOP_LB  = 3'b010;
  localparam logic [2:0] MEMOP_LBU = 3'b011;
  localparam logic [2:0] MEMOP_LHU = 3'b100;
  localparam logic [2:0] MEMOP_SW  = 3'b101;
  localparam logic [2:0] MEMOP_SB  = 3'b110;
  localparam logic [2:0] MEMOP_SH  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_ACK_TIMEOUT = 255;

  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [3:0]  DEFAULT_BE    = 4'b0000;
  localparam logic [7:0]  DEFAULT_COUNT = 8'd0;

  function automatic logic is_load(input logic [2:0] op);
    return (op == MEMOP_LW) || (op == MEMOP_LB) || (op == MEMOP_LBU) || (op == MEMOP_LHU);
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op == MEMOP_SW) || (op == MEMOP_SB) || (op == MEMOP_SH);
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: purely combinational byte-lane handling. Generates byte
// enables and lane-replicated store data for the op being issued, and
// extracts/extends load data for the op currently outstanding on the bus.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  st_op,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Byte enables and store-data replication for the issuing op
  always_comb begin
    be    = DEFAULT_BE;
    wdata = ZERO_WORD;
    case (st_op)
      MEMOP_SB: begin
        be    = 4'b0001 << st_offset;
        wdata = {4{st_data[7:0]}};
      end
      MEMOP_SH: begin
        be    = st_offset[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
      end
      MEMOP_SW: begin
        be    = 4'b1111;
        wdata = st_data;
      end
      MEMOP_LW, MEMOP_LB, MEMOP_LBU, MEMOP_LHU: be = 4'b1111;
      default: ;
    endcase
  end

  // Lane select and sign/zero extension of read data
  always_comb begin
    ld_byte = rdata[{ld_offset, 3'b000} +: 8];
    ld_half = ld_offset[1] ? rdata[31:16] : rdata[15:0];
    ld_data = ZERO_WORD;
    case (ld_op)
      MEMOP_LW:  ld_data = rdata;
      MEMOP_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      MEMOP_LBU: ld_data = {24'h00_0000, ld_byte};
      MEMOP_LHU: ld_data = {16'h0000, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine over a req/ack bus. Stalls
// the pipeline while an access is outstanding and aborts on ack timeout.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned LW/SW/LHU/SH skip the
// bus and complete immediately with a bus error.
//
// state | meaning
// IDLE  | waiting for a memory op; issues the bus request when one arrives
// BUSY  | request outstanding; waits for ack or timeout
// DONE  | access finished; pipeline advances this cycle
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result_i,
  input  logic [31:0] MemData_i,
  input  logic [2:0]  MemOp_i,
  input  logic [4:0]  WriteRegDst_i,
  input  logic        RegWrite_i,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_req_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  WriteRegDst_o,
  output logic        RegWrite_o,
  output logic        bus_err_o
);

  state_t      state, state_next;
  logic [7:0]  cnt;
  logic [31:0] ld_q;
  logic [2:0]  op_q;
  logic [1:0]  offset_q;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] ld_c;
  logic        op_valid;
  logic        misalign;
  logic        timeout;

  assign op_valid = (MemOp_i != MEMOP_NOP);
  assign timeout  = (cnt == 8'(ACK_TIMEOUT - 1));

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (((MemOp_i == MEMOP_LW) || (MemOp_i == MEMOP_SW)) && (result_i[1:0] != 2'b00)) ||
                    (((MemOp_i == MEMOP_LHU) || (MemOp_i == MEMOP_SH)) && result_i[0]);
`else
  assign misalign = 1'b0;
`endif

  // Load extraction uses the op/offset latched at issue, not the live inputs
  mem_lane_align u_lane (
    .st_op     (MemOp_i),
    .st_offset (result_i[1:0]),
    .st_data   (MemData_i),
    .be        (be_c),
    .wdata     (wdata_c),
    .ld_op     (op_q),
    .ld_offset (offset_q),
    .rdata     (mem_rdata),
    .ld_data   (ld_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic; ack is tested before timeout so it wins a tie
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (op_valid) state_next = misalign ? ST_DONE : ST_BUSY;
      ST_BUSY: if (mem_ack || timeout) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered bus signals, load capture, timeout counter and error pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= ZERO_WORD;
      mem_be    <= DEFAULT_BE;
      mem_wdata <= ZERO_WORD;
      ld_q      <= ZERO_WORD;
      cnt       <= DEFAULT_COUNT;
      bus_err_o <= 1'b0;
      op_q      <= MEMOP_NOP;
      offset_q  <= 2'b00;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid && misalign) begin
            ld_q      <= ZERO_WORD;
            bus_err_o <= 1'b1;
          end else if (op_valid) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store(MemOp_i);
            mem_addr  <= {result_i[31:2], 2'b00};
            mem_be    <= be_c;
            mem_wdata <= wdata_c;
            op_q      <= MemOp_i;
            offset_q  <= result_i[1:0];
            cnt       <= DEFAULT_COUNT;
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            ld_q    <= ld_c;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else if (timeout) begin
            ld_q      <= ZERO_WORD;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            bus_err_o <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stall and write-back outputs; bus_err_o is high only in a failed DONE
  always_comb begin
    stall_req_o = 1'b0;
    RegWrite_o  = 1'b0;
    wb_data_o   = result_i;
    case (state)
      ST_IDLE: begin
        stall_req_o = op_valid;
        RegWrite_o  = op_valid ? 1'b0 : RegWrite_i;
      end
      ST_BUSY: stall_req_o = 1'b1;
      ST_DONE: begin
        RegWrite_o = RegWrite_i & ~bus_err_o;
        if (is_load(MemOp_i)) wb_data_o = ld_q;
      end
      default: ;
    endcase
  end

  assign WriteRegDst_o = WriteRegDst_i;

endmodule
